// File: rtl/pbus_pkg.sv
// ---------------------------------------------------------------------------
// pbus_pkg
//   Shared definitions for the 8-bit peripheral register bus (cs/rw/AD/DI/DO).
//   Used by the bus master, by peripheral models and by benches so that the
//   state encoding and the read/write polarity are defined in exactly one place.
//
//   Contents:
//     pbus_state_e : master sequencing states IDLE, ISSUE, DRAIN, RESP
//     PBUS_DW      : bus data width (one byte per bus cycle)
//     PBUS_RD/WR   : encodings of the rw strobe (1 = read, 0 = write)
// ---------------------------------------------------------------------------
package pbus_pkg;

  localparam int PBUS_DW = 8;

  localparam logic PBUS_RD = 1'b1;
  localparam logic PBUS_WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } pbus_state_e;

endpackage

// File: rtl/periph_bus_master.sv
// ---------------------------------------------------------------------------
// periph_bus_master
//   Initiator for the 8-bit peripheral register bus. One word request
//   (BYTES bytes, read or write) taken on a valid/ready port is expanded into
//   BYTES back-to-back byte cycles at ascending (wrapping) addresses. Read
//   bytes come back one cycle after their select and are assembled into a
//   single word; a completion is returned on a valid/ready response port.
//
//   Byte 0 is the most significant byte of the word and goes to the base
//   address; byte k sits at word[8*(BYTES-k)-1 -: 8] and address base+k.
//
//   Parameters
//     AW     peripheral address width (addresses wrap modulo 2**AW)
//     BYTES  bytes per word transfer (>= 1)
//
//   Ports
//     clk, rst             clock, synchronous active-high reset
//     req_valid/req_ready  request handshake
//     req_rw               1 = read, 0 = write
//     req_addr             base byte address
//     req_wdata            write word
//     rsp_valid/rsp_ready  response handshake (one per request)
//     rsp_rdata            assembled read word, 0 for writes
//     bus_cs               peripheral select, one cycle per byte
//     bus_rw               1 = read cycle (idles high)
//     bus_ad               byte address (holds last value between transfers)
//     bus_do               write byte to peripheral, 0 on reads and idle
//     bus_di               registered read byte from peripheral
//
//   All outputs are registered. A reset mid-transfer abandons the transfer:
//   the select drops the cycle after the reset edge and no response is made.
// ---------------------------------------------------------------------------
module periph_bus_master
  import pbus_pkg::*;
#(
  parameter int AW    = 3,
  parameter int BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rw,
  input  logic [AW-1:0]            req_addr,
  input  logic [PBUS_DW*BYTES-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [PBUS_DW*BYTES-1:0] rsp_rdata,
  output logic                     bus_cs,
  output logic                     bus_rw,
  output logic [AW-1:0]            bus_ad,
  output logic [PBUS_DW-1:0]       bus_do,
  input  logic [PBUS_DW-1:0]       bus_di
);

  localparam int WW = PBUS_DW * BYTES;
  localparam int CW = $clog2(BYTES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTES);

  pbus_state_e     state;
  logic            rw_q;       // latched direction of the transfer in flight
  logic [CW-1:0]   cnt;        // number of byte cycles issued so far
  logic            rd_vld_p1;  // bus_di carries a read byte this cycle
  logic [WW-1:0]   wsh;        // remaining write bytes, next one at the top
  logic [WW-1:0]   rsh;        // read bytes collected so far, newest at the bottom

  // Append one byte at the bottom of the word, pushing older bytes upward so
  // that the first byte collected ends up in the most significant slot.
  function automatic logic [WW-1:0] shift_in(input logic [WW-1:0] w,
                                             input logic [PBUS_DW-1:0] b);
    logic [WW-1:0] r;
    r = w << PBUS_DW;
    r[PBUS_DW-1:0] = b;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      bus_cs    <= 1'b0;
      bus_rw    <= PBUS_RD;
      bus_ad    <= '0;
      bus_do    <= '0;
      cnt       <= '0;
      rw_q      <= PBUS_RD;
      rd_vld_p1 <= 1'b0;
    end else begin
      // A read select this cycle means the peripheral presents data next cycle.
      rd_vld_p1 <= bus_cs && (bus_rw == PBUS_RD);

      case (state)
        IDLE: begin
          // req_ready is high throughout IDLE, so valid alone is the handshake.
          if (req_valid) begin
            req_ready <= 1'b0;
            rw_q      <= req_rw;
            state     <= ISSUE;
            bus_cs    <= 1'b1;
            bus_rw    <= req_rw;
            bus_ad    <= req_addr;
            bus_do    <= (req_rw == PBUS_RD) ? '0 : req_wdata[WW-1 -: PBUS_DW];
            cnt       <= CW'(1);
          end
        end

        ISSUE: begin
          if (cnt == LAST_CNT) begin
            bus_cs <= 1'b0;
            bus_rw <= PBUS_RD;
            bus_do <= '0;
            if (rw_q == PBUS_WR) begin
              // Writes complete as soon as the last byte has been presented.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= DRAIN;
            end
          end else begin
            bus_ad <= bus_ad + AW'(1);
            bus_do <= (rw_q == PBUS_RD) ? '0 : wsh[WW-1 -: PBUS_DW];
            cnt    <= cnt + CW'(1);
          end
        end

        DRAIN: begin
          // The last read byte is on bus_di now; fold it in on the way out.
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= shift_in(rsh, bus_di);
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Data shift registers (no reset: contents are fully overwritten per transfer)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      wsh <= req_wdata << PBUS_DW;
    end else if (state == ISSUE) begin
      wsh <= wsh << PBUS_DW;
    end
    if (rd_vld_p1) begin
      rsh <= shift_in(rsh, bus_di);
    end
  end

endmodule

// File: tb/tb_periph_bus_master.sv
// ---------------------------------------------------------------------------
// tb_periph_bus_master
//   Bench for periph_bus_master (AW=3, BYTES=4) attached to a behavioural
//   28-bit GPIO peripheral: addresses 0..3 hold the output/pin word, 4..7 the
//   direction word (byte 0 = MS byte, bits 31:28 read as zero). Pins driven
//   by the GPIO where dir=1, by the bench (g_ext) elsewhere. Expected
//   responses are queued when a request is issued and compared against what
//   the response monitor records at each handshake.
// ---------------------------------------------------------------------------
module tb_periph_bus_master;
  import pbus_pkg::*;

  localparam int AW    = 3;
  localparam int BYTES = 4;
  localparam int WW    = 8 * BYTES;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [WW-1:0] rsp_rdata;
  logic          bus_cs;
  logic          bus_rw;
  logic [AW-1:0] bus_ad;
  logic [7:0]    bus_do;
  logic [7:0]    bus_di = 8'h00;

  periph_bus_master #(.AW(AW), .BYTES(BYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .bus_cs    (bus_cs),
    .bus_rw    (bus_rw),
    .bus_ad    (bus_ad),
    .bus_do    (bus_do),
    .bus_di    (bus_di)
  );

  always #5 clk = ~clk;

  // ---------------- GPIO peripheral model ----------------
  logic [27:0] g_out = '0;
  logic [27:0] g_dir = '0;
  logic [27:0] g_ext = '0;
  logic [27:0] g_pins;
  logic [31:0] pw;
  int          pidx;

  assign g_pins = (g_dir & g_out) | (~g_dir & g_ext);

  function automatic logic [7:0] gpio_byte(input logic [2:0] a);
    logic [31:0] w;
    int          i;
    w = a[2] ? {4'h0, g_dir} : {4'h0, g_pins};
    i = 8 * (3 - int'(a[1:0]));
    return w[i +: 8];
  endfunction

  always @(posedge clk) begin
    if (bus_cs && bus_rw == PBUS_WR) begin
      pidx = 8 * (3 - int'(bus_ad[1:0]));
      pw   = bus_ad[2] ? {4'h0, g_dir} : {4'h0, g_out};
      pw[pidx +: 8] = bus_do;
      if (bus_ad[2]) g_dir <= pw[27:0];
      else           g_out <= pw[27:0];
    end
    bus_di <= (bus_cs && bus_rw == PBUS_RD) ? gpio_byte(bus_ad) : 8'h00;
  end

  // ---------------- bus / handshake monitor (negedge) ----------------
  int          cyc        = 0;
  int          cs_total   = 0;
  int          cs_run     = 0;
  int          rd_do_bad  = 0;
  int          idle_bad   = 0;
  int          runs[$];
  int          acc_cyc[$];
  logic [2:0]  ad_log[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (bus_cs) begin
      cs_total++;
      cs_run++;
      ad_log.push_back(bus_ad);
      if (bus_rw == PBUS_RD && bus_do !== 8'h00) rd_do_bad++;
    end else begin
      if (cs_run > 0) runs.push_back(cs_run);
      cs_run = 0;
      if (!rst && (bus_rw !== 1'b1 || bus_do !== 8'h00)) idle_bad++;
    end
    if (!rst && req_valid && req_ready) acc_cyc.push_back(cyc);
    if (!rst && rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request and hold it until accepted; returns cycles waited.
  task automatic start_req(input string tag, input logic rw, input logic [2:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp,
                           output int waits);
    logic ok;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    waits     = 0;
    do begin
      ok = req_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!ok && waits < 100);
    check({tag, "_accept"}, 32'(ok), 32'd1);
    req_valid = 1'b0;
    req_rw    = 1'($urandom_range(0, 1));
    req_addr  = 3'($urandom_range(0, 7));
    req_wdata = $urandom();
    exp_q.push_back(exp);
  endtask

  // Called in cycle T+1; returns the cycle offset (from T) of rsp_valid.
  task automatic wait_rsp(input string tag, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_rsp_seen"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_rdata"}, got_q.pop_front(), exp_q.pop_front());
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, waits, cs0, bad, acc0, guard;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    step(3);

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_bus_cs",    32'(bus_cs), 32'd0);
    check("rst_bus_rw",    32'(bus_rw), 32'd1);
    check("rst_bus_ad",    32'(bus_ad), 32'd0);
    check("rst_bus_do",    32'(bus_do), 32'd0);
    rst = 1'b0;
    step(2);

    // Write direction register, then the output word.
    cs0 = cs_total;
    start_req("wr_dir", PBUS_WR, 3'd4, 32'h0000_00FF, 32'h0, waits);
    wait_rsp("wr_dir", lat);
    check("wr_dir_lat", 32'(lat), 32'(BYTES + 1));
    check("wr_dir_rdata_zero", rsp_rdata, 32'h0);
    handshake("wr_dir");
    check("wr_dir_cs_cycles", 32'(cs_total - cs0), 32'd4);
    check("gpio_dir", {4'h0, g_dir}, 32'h0000_00FF);

    cs0 = cs_total;
    start_req("wr_out", PBUS_WR, 3'd0, 32'h0ABC_DEF1, 32'h0, waits);
    wait_rsp("wr_out", lat);
    check("wr_out_lat", 32'(lat), 32'(BYTES + 1));
    handshake("wr_out");
    check("wr_out_cs_cycles", 32'(cs_total - cs0), 32'd4);
    check("gpio_out", {4'h0, g_out}, 32'h0ABC_DEF1);

    // Read back direction.
    start_req("rd_dir", PBUS_RD, 3'd4, 32'hFFFF_FFFF, 32'h0000_00FF, waits);
    wait_rsp("rd_dir", lat);
    check("rd_dir_lat", 32'(lat), 32'(BYTES + 2));
    handshake("rd_dir");

    // Read pins: low byte from GPIO outputs, upper 20 bits from the bench.
    g_ext = 28'hABCDE00;
    start_req("rd_pins", PBUS_RD, 3'd0, 32'h0, 32'h0ABC_DEF1, waits);
    wait_rsp("rd_pins", lat);
    handshake("rd_pins");

    // Address wrap from base 6.
    ad_log.delete();
    start_req("rd_wrap", PBUS_RD, 3'd6, 32'h0, 32'h00FF_0ABC, waits);
    wait_rsp("rd_wrap", lat);
    handshake("rd_wrap");
    check("wrap_ad_count", 32'(ad_log.size()), 32'd4);
    if (ad_log.size() == 4) begin
      check("wrap_ad0", 32'(ad_log[0]), 32'd6);
      check("wrap_ad1", 32'(ad_log[1]), 32'd7);
      check("wrap_ad2", 32'(ad_log[2]), 32'd0);
      check("wrap_ad3", 32'(ad_log[3]), 32'd1);
    end

    // Response backpressure with a second request waiting.
    start_req("bp_rd", PBUS_RD, 3'd4, 32'h0, 32'h0000_00FF, waits);
    wait_rsp("bp_rd", lat);
    req_rw    = PBUS_WR;
    req_addr  = 3'd4;
    req_wdata = 32'h0000_00FF;
    req_valid = 1'b1;
    acc0 = acc_cyc.size();
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00FF ||
          req_ready !== 1'b0 || bus_cs !== 1'b0) bad++;
      step(1);
    end
    check("bp_hold_bad_cycles", 32'(bad), 32'd0);
    check("bp_no_accept", 32'(acc_cyc.size() - acc0), 32'd0);
    handshake("bp_rd");
    start_req("bp_wr", PBUS_WR, 3'd4, 32'h0000_00FF, 32'h0, waits);
    check("bp_wr_accept_wait", 32'(waits), 32'd1);
    wait_rsp("bp_wr", lat);
    handshake("bp_wr");
    bad = 0;
    foreach (runs[i]) if (runs[i] != 4) bad++;
    check("cs_runs_len4", 32'(bad), 32'd0);

    // Reset during a write: bytes 0-1 land, bytes 2-3 do not.
    start_req("rst_wr", PBUS_WR, 3'd0, 32'h1122_3344, 32'h0, waits);
    void'(exp_q.pop_back());
    step(1);
    rst = 1'b1;
    step(1);
    check("rst_mid_cs_low", 32'(bus_cs), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) bad++;
      step(1);
    end
    check("rst_mid_no_rsp", 32'(bad), 32'd0);
    check("rst_mid_gpio_out", {4'h0, g_out}, 32'h0122_DEF1);

    // Back-to-back read, write, read with req_valid held and rsp_ready high.
    runs.delete();
    acc_cyc.delete();
    rd_do_bad = 0;
    rsp_ready = 1'b1;
    req_rw    = PBUS_RD;
    req_addr  = 3'd4;
    req_wdata = 32'hA5A5_A5A5;
    req_valid = 1'b1;
    exp_q.push_back(32'h0000_00FF);
    for (int n = 1; n <= 3; n++) begin
      guard = 0;
      while (acc_cyc.size() < n && guard < 64) begin
        step(1);
        guard++;
      end
      if (n == 1) begin
        req_rw = PBUS_WR; req_addr = 3'd4; req_wdata = 32'h0000_00FF;
        exp_q.push_back(32'h0);
      end else if (n == 2) begin
        req_rw = PBUS_RD; req_addr = 3'd4; req_wdata = 32'h5A5A_5A5A;
        exp_q.push_back(32'h0000_00FF);
      end else begin
        req_valid = 1'b0;
      end
    end
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    guard = 0;
    while (got_q.size() < 3 && guard < 64) begin
      step(1);
      guard++;
    end
    rsp_ready = 1'b0;
    check("b2b_rsp_count", 32'(got_q.size()), 32'd3);
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("b2b_rdata", got_q.pop_front(), exp_q.pop_front());
    if (acc_cyc.size() == 3) begin
      check("b2b_rd_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(BYTES + 3));
      check("b2b_wr_spacing", 32'(acc_cyc[2] - acc_cyc[1]), 32'(BYTES + 2));
    end
    step(2);
    bad = 0;
    foreach (runs[i]) if (runs[i] != 4) bad++;
    check("b2b_cs_runs", 32'(runs.size()), 32'd3);
    check("b2b_cs_len4", 32'(bad), 32'd0);
    check("b2b_read_do_zero", 32'(rd_do_bad), 32'd0);
    check("idle_bus_levels", 32'(idle_bad), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size() + got_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
